// File: rtl/enc_huff_bitpack.sv
// Huffman back end: packs right-justified variable-length codewords MSB-first into
// a JPEG entropy-coded byte stream with 0xFF/0x00 stuffing and 1-padding at end-of-stream.
module enc_huff_bitpack #(
  parameter int MAXLEN = 16,
  parameter int ACCW   = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] codeBits_d,
  input  logic        codeBits_e,
  input  logic        codeBits_v,
  output logic        codeBits_b,
  input  logic [7:0]  codeLen_d,
  input  logic        codeLen_e,
  input  logic        codeLen_v,
  output logic        codeLen_b,
  output logic [7:0]  filebyte_d,
  output logic        filebyte_e,
  output logic        filebyte_v,
  input  logic        filebyte_b,
  output logic [2:0]  dbg_state
);

  // Stream handshake: a token moves on a rising edge with _v=1 and _b=0; a presented
  // output token (_d/_e/_v) is held unchanged while filebyte_b=1.
  localparam int CW = $clog2(ACCW + 1);

  typedef enum logic [2:0] {
    S_RUN   = 3'd0,
    S_STUFF = 3'd1,
    S_PAD   = 3'd2,
    S_EOS   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q, state_n;
  logic [ACCW-1:0] acc_q, acc_n, acc_a, code_m;
  logic [CW-1:0]   cnt_q, cnt_n, cnt_a, len_eff;
  logic            eos_q, eos_n;
  logic [7:0]      fb_d_q, fb_d_n;
  logic            fb_e_q, fb_e_n, fb_v_q, fb_v_n;

  logic       out_free, room, in_open, accept, tok_eos, has_byte;
  logic [7:0] top_byte, pad_byte;

  assign out_free = !fb_v_q || !filebyte_b;
  assign room     = cnt_q <= CW'(ACCW - MAXLEN);
  assign in_open  = room && (state_q == S_RUN || state_q == S_STUFF);
  assign accept   = reset && in_open && codeBits_v && codeLen_v;
  assign tok_eos  = codeBits_e || codeLen_e;

  assign codeBits_b = !reset || !in_open;
  assign codeLen_b  = !reset || !in_open;

  // The EOS token carries no payload, so it appends nothing.
  always_comb begin
    len_eff = '0;
    if (accept && !tok_eos) begin
      if (codeLen_d > 8'(MAXLEN)) len_eff = CW'(MAXLEN);
      else                        len_eff = CW'(codeLen_d);
    end
  end

  // Emission looks at the accumulator after this cycle's append so a completed byte
  // is presented right after the edge that accepted its last bit.
  assign code_m   = ACCW'(codeBits_d) & ~({ACCW{1'b1}} << len_eff);
  assign acc_a    = accept ? ((acc_q << len_eff) | code_m) : acc_q;
  assign cnt_a    = cnt_q + len_eff;
  assign has_byte = cnt_a >= CW'(8);
  assign top_byte = 8'(acc_a >> (cnt_a - CW'(8)));
  assign pad_byte = 8'(acc_q << (CW'(8) - cnt_q)) | (8'hFF >> cnt_q);

  always_comb begin
    state_n = state_q;
    acc_n   = acc_a;
    cnt_n   = cnt_a;
    eos_n   = eos_q || (accept && tok_eos);
    fb_d_n  = fb_d_q;
    fb_e_n  = fb_e_q;
    fb_v_n  = fb_v_q;
    if (fb_v_q && !filebyte_b) begin
      fb_v_n = 1'b0;
      fb_e_n = 1'b0;
    end
    case (state_q)
      S_RUN: begin
        if (out_free && has_byte) begin
          fb_d_n = top_byte;
          fb_e_n = 1'b0;
          fb_v_n = 1'b1;
          cnt_n  = cnt_a - CW'(8);
          if (top_byte == 8'hFF) state_n = S_STUFF;
          else if (eos_n)        state_n = S_PAD;
        end else if (eos_n) begin
          state_n = S_PAD;
        end
      end
      S_STUFF: begin
        if (out_free) begin
          fb_d_n  = 8'h00;
          fb_e_n  = 1'b0;
          fb_v_n  = 1'b1;
          state_n = eos_n ? S_PAD : S_RUN;
        end
      end
      S_PAD: begin
        if (out_free) begin
          fb_v_n = 1'b1;
          fb_e_n = 1'b0;
          if (has_byte) begin
            fb_d_n = top_byte;
            cnt_n  = cnt_a - CW'(8);
            if (top_byte == 8'hFF) state_n = S_STUFF;
          end else if (cnt_q != '0) begin
            fb_d_n = pad_byte;
            cnt_n  = '0;
            if (pad_byte == 8'hFF) state_n = S_STUFF;
          end else begin
            fb_d_n  = 8'h00;
            fb_e_n  = 1'b1;
            state_n = S_EOS;
          end
        end
      end
      S_EOS: begin
        if (fb_v_q && !filebyte_b) state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_DONE;
      end
      default: begin
        state_n = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_RUN;
      acc_q   <= '0;
      cnt_q   <= '0;
      eos_q   <= 1'b0;
      fb_d_q  <= 8'h00;
      fb_e_q  <= 1'b0;
      fb_v_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      acc_q   <= acc_n;
      cnt_q   <= cnt_n;
      eos_q   <= eos_n;
      fb_d_q  <= fb_d_n;
      fb_e_q  <= fb_e_n;
      fb_v_q  <= fb_v_n;
    end
  end

  assign filebyte_d = fb_d_q;
  assign filebyte_e = fb_e_q;
  assign filebyte_v = fb_v_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_enc_huff_bitpack.sv
// Bench for enc_huff_bitpack: directed and random codeword streams checked against a
// bit-queue model of the packed, stuffed and padded byte stream.
module tb_enc_huff_bitpack;

  localparam int MAXLEN = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] codeBits_d = '0;
  logic        codeBits_e = 1'b0, codeBits_v = 1'b0;
  logic        codeBits_b;
  logic [7:0]  codeLen_d = '0;
  logic        codeLen_e = 1'b0, codeLen_v = 1'b0;
  logic        codeLen_b;
  logic [7:0]  filebyte_d;
  logic        filebyte_e, filebyte_v;
  logic        filebyte_b = 1'b0;
  logic [2:0]  dbg_state;

  enc_huff_bitpack #(.MAXLEN(MAXLEN), .ACCW(32)) dut (
    .clock(clock), .reset(reset),
    .codeBits_d(codeBits_d), .codeBits_e(codeBits_e), .codeBits_v(codeBits_v), .codeBits_b(codeBits_b),
    .codeLen_d(codeLen_d), .codeLen_e(codeLen_e), .codeLen_v(codeLen_v), .codeLen_b(codeLen_b),
    .filebyte_d(filebyte_d), .filebyte_e(filebyte_e), .filebyte_v(filebyte_v), .filebyte_b(filebyte_b),
    .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic       bit_q[$];
  logic [7:0] exp_q[$];
  bit         eos_seen = 1'b0;
  bit         bp_rand  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: codeword bits in arrival order, cut into bytes, 0x00 after 0xFF.
  task automatic model_drain();
    logic [7:0] b;
    while (bit_q.size() >= 8) begin
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], bit_q.pop_front()};
      exp_q.push_back(b);
      if (b == 8'hFF) exp_q.push_back(8'h00);
    end
  endtask

  task automatic model_bits(input logic [15:0] c, input int l);
    int ll;
    ll = (l > MAXLEN) ? MAXLEN : l;
    for (int i = ll - 1; i >= 0; i--) bit_q.push_back(c[i]);
    model_drain();
  endtask

  task automatic model_eos();
    while (bit_q.size() % 8 != 0) bit_q.push_back(1'b1);
    model_drain();
  endtask

  task automatic monitor_loop();
    bit         hold_prev = 1'b0;
    logic [9:0] prev_tok = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) check("hold_stable", {22'd0, filebyte_v, filebyte_e, filebyte_d}, {22'd0, prev_tok});
        if (filebyte_v && !filebyte_b) begin
          if (filebyte_e) begin
            check("eos_data", {24'd0, filebyte_d}, 32'h0);
            check("eos_left", exp_q.size(), 32'd0);
            eos_seen = 1'b1;
          end else if (exp_q.size() == 0) begin
            check("extra_byte", {24'd0, filebyte_d}, 32'h100);
          end else begin
            check("out_byte", {24'd0, filebyte_d}, {24'd0, exp_q.pop_front()});
          end
        end
        hold_prev = filebyte_v && filebyte_b;
        prev_tok  = {filebyte_v, filebyte_e, filebyte_d};
      end
    end
  endtask

  task automatic bp_loop();
    forever begin
      @(posedge clock);
      #1;
      if (bp_rand) filebyte_b = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("rst_out", {29'd0, filebyte_v, filebyte_e, |filebyte_d}, 32'd0);
    check("rst_b", {30'd0, codeBits_b, codeLen_b}, 32'd3);
    bit_q.delete();
    exp_q.delete();
    eos_seen = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check("rel_b", {30'd0, codeBits_b, codeLen_b}, 32'd0);
  endtask

  task automatic send(input logic [15:0] c, input logic [7:0] l, input logic be, input logic le);
    bit took = 1'b0;
    codeBits_d = c;  codeLen_d = l;
    codeBits_e = be; codeLen_e = le;
    codeBits_v = 1'b1; codeLen_v = 1'b1;
    for (int i = 0; i < 1000 && !took; i++) begin
      @(negedge clock);
      check("b_equal", {31'd0, codeBits_b}, {31'd0, codeLen_b});
      if (!codeBits_b) took = 1'b1;
      @(posedge clock);
      #1;
    end
    codeBits_v = 1'b0; codeLen_v = 1'b0;
    codeBits_e = 1'b0; codeLen_e = 1'b0;
    check("tok_accept", {31'd0, took}, 32'd1);
    if (took) begin
      if (be || le) model_eos();
      else          model_bits(c, int'(l));
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && !eos_seen; i++) begin
      @(posedge clock);
      #1;
    end
    check("eos_reached", {31'd0, eos_seen}, 32'd1);
    repeat (2) @(posedge clock);
    #1;
    check("done_idle", {30'd0, codeBits_b, filebyte_v}, 32'd2);
  endtask

  initial begin
    fork
      monitor_loop();
      bp_loop();
    join_none

    do_reset();
    send(16'b101, 8'd3, 1'b0, 1'b0);
    send(16'b11001, 8'd5, 1'b0, 1'b0);
    send(16'h0, 8'd0, 1'b1, 1'b1);
    wait_done();

    do_reset();
    send(16'h00FF, 8'd8, 1'b0, 1'b0);
    send(16'h0012, 8'd8, 1'b0, 1'b0);
    send(16'h0, 8'd0, 1'b1, 1'b1);
    wait_done();

    do_reset();
    send(16'h0, 8'd1, 1'b0, 1'b0);
    send(16'h0, 8'd0, 1'b1, 1'b1);
    wait_done();

    do_reset();
    send(16'hF, 8'd4, 1'b0, 1'b0);
    send(16'h0, 8'd0, 1'b1, 1'b1);
    wait_done();

    // Output held: the input side must stall, then everything drains byte-exact.
    do_reset();
    filebyte_b = 1'b1;
    fork
      begin
        for (int k = 0; k < 16; k++) send(16'hABCD, 8'd16, 1'b0, 1'b0);
      end
      begin
        repeat (20) @(posedge clock);
        #2;
        check("stall_b", {30'd0, codeBits_b, codeLen_b}, 32'd3);
        filebyte_b = 1'b0;
      end
    join
    send(16'h0, 8'd0, 1'b1, 1'b1);
    wait_done();

    // Reset while a byte is held and 5 bits are buffered.
    do_reset();
    filebyte_b = 1'b1;
    send(16'h00AB, 8'd8, 1'b0, 1'b0);
    send(16'h0015, 8'd5, 1'b0, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    check("held_byte", {31'd0, filebyte_v}, 32'd1);
    do_reset();
    filebyte_b = 1'b0;
    send(16'h00A5, 8'd8, 1'b0, 1'b0);
    send(16'h0, 8'd0, 1'b1, 1'b1);
    wait_done();

    // Random streams: lengths past MAXLEN, zero-length tokens, mismatched EOS flags.
    bp_rand = 1'b1;
    for (int s = 0; s < 6; s++) begin
      int n_tok;
      int kind;
      do_reset();
      n_tok = $urandom_range(10, 40);
      for (int k = 0; k < n_tok; k++) begin
        send(16'($urandom), 8'($urandom_range(0, 20)), 1'b0, 1'b0);
        repeat ($urandom_range(0, 2)) @(posedge clock);
        #1;
      end
      kind = $urandom_range(0, 2);
      send(16'($urandom), 8'($urandom_range(0, 16)), kind != 2, kind != 1);
      wait_done();
    end
    bp_rand = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/enc_huff_bitpack.md
Name: enc_huff_bitpack

Overview:
- Huffman encoder back end: packs variable-length codewords (MSB-first) into the JPEG entropy-coded byte stream.
- Inserts 0x00 after every 0xFF data byte; on end-of-stream, pads to a byte boundary with 1s.
- Writing counterpart of the Huffman decode stage's bit reader: its filebyte output feeds that reader directly.
- Uses the team's stream handshake on all streams: _d data, _e end-of-stream, _v valid, _b back-pressure.

Parameters:
- MAXLEN, 16, maximum codeword length in bits; codeLen_d values above MAXLEN are clamped to MAXLEN.
- ACCW, 32, bit-accumulator width; must be at least MAXLEN+8.

Ports:
- clock  input  1  single system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- codeBits_d  input  16  codeword, right-justified; only the low codeLen bits are used.
- codeBits_e  input  1  end-of-stream marker (valid with codeBits_v).
- codeBits_v  input  1  codeBits token valid.
- codeBits_b  output  1  back-pressure to codeBits producer.
- codeLen_d  input  8  codeword length, 0..MAXLEN.
- codeLen_e  input  1  end-of-stream marker.
- codeLen_v  input  1  codeLen token valid.
- codeLen_b  output  1  back-pressure to codeLen producer.
- filebyte_d  output  8  packed output byte.
- filebyte_e  output  1  end-of-stream marker on output.
- filebyte_v  output  1  output token valid.
- filebyte_b  input  1  back-pressure from consumer.

Behaviour:
- Handshake:
  - A token transfers on a rising edge where _v=1 and _b=0.
  - Output _d/_e/_v stay stable while filebyte_b=1.
  - Input tokens are consumed only as a pair: both _v high and room available. codeBits_b and codeLen_b are always equal.
- Reset (reset=0, asynchronous):
  - filebyte_d=0, filebyte_e=0, filebyte_v=0, codeBits_b=1, codeLen_b=1.
  - Accumulator and bit count cleared; state RUN.
  - First cycle after release: codeBits_b=codeLen_b=0.
  - Reset asserted mid-operation discards all buffered bits, with no partial output.
- Accumulator: ACCW bits, bit count cnt holds 0..ACCW.
  - Room available when cnt+MAXLEN <= ACCW.
  - An accepted token appends the low L bits at the tail: acc = (acc<<L) | code[L-1:0], cnt += L.
  - L=0 is accepted with no change.
- States:
  - RUN:
    - Accepts tokens when there is room.
    - When cnt>=8 and the output register is free (filebyte_v=0, or the current byte transfers this cycle), loads the top 8 buffered bits into filebyte_d, sets filebyte_v, and subtracts 8 from cnt.
    - Accept and emit may occur in the same cycle; cnt += L-8.
    - If the emitted byte is 0xFF, go to STUFF.
    - On an accepted token with both _e=1, go to PAD. codeBits_d/codeLen_d of the EOS token are ignored.
  - STUFF: next output token is 0x00. Inputs are still accepted if there is room. Return to RUN (or to PAD, if EOS was already seen) after 0x00 is loaded.
  - PAD:
    - No further input accepted; _b=1.
    - Drain full bytes as in RUN, including stuffing.
    - Then, if 0<cnt<8, append 8-cnt one-bits and emit that byte. If the padded byte is 0xFF, stuff a 0x00 after it.
    - Then go to EOS.
  - EOS: present filebyte_e=1, filebyte_v=1, filebyte_d=0. After transfer, go to DONE.
  - DONE: _b=1 on inputs, filebyte_v=0. Leaves only via reset.
- Latency: a byte completed by a token accepted on edge N is valid at filebyte_v after edge N (registered output, 1 cycle).
- Throughput: one output byte per cycle when not back-pressured.
- Mismatched EOS (only one of codeBits_e / codeLen_e set on an accepted pair) is treated as EOS.
- Each output byte is MSB-first: the earliest codeword bit is filebyte_d[7].

Test Plan:
- Tokens (code 0b101, len 3), (0b11001, len 5), then EOS, no back-pressure -> one byte 0xB9, then EOS token filebyte_e=1; no pad byte emitted.
- Tokens (0xFF, len 8), (0x12, len 8), EOS -> bytes 0xFF, 0x00, 0x12, then EOS.
- Token (0b0, len 1), EOS -> pad byte 0x7F, then EOS.
- Token (0b1111, len 4), EOS -> pad yields 0xFF; output 0xFF, 0x00, then EOS.
- Sixteen tokens (0xABCD, len 16) with filebyte_b=1 held:
  - codeBits_b rises once cnt exceeds ACCW-MAXLEN; no token is lost.
  - After filebyte_b is released, output is the repeating sequence 0xAB, 0xCD, byte-exact.
- Reset pulse (reset=0 for 1 cycle) mid-stream with 5 buffered bits -> filebyte_v=0 immediately; stream restarts cleanly, and the next tokens (0xA5, len 8) yield byte 0xA5.
